// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions used by the divider and its multiplier companion.
`timescale 1ns/1ps
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Divide-by-zero quotient is every bit set to this value (all ones).
  localparam bit DIV0_QUOTIENT_ALL_ONES = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-and-subtract iteration: shift in the next dividend bit,
// subtract the divisor, keep the difference only if it did not go negative.
`timescale 1ns/1ps
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_w,
  input  logic [WIDTH-1:0] quo_w,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_rem_msb;

  // The partial remainder never reaches WIDTH+1 significant bits, so its MSB is dropped by the shift.
  assign unused_rem_msb = rem_w[WIDTH];

  assign shifted  = {rem_w[WIDTH-1:0], quo_w[WIDTH-1]};
  assign trial    = shifted - {1'b0, dsr};
  assign rem_next = trial[WIDTH] ? shifted : trial;
  assign quo_next = {quo_w[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, with a
// single-shot in_valid/out_valid handshake matching the sequential multiplier.
`timescale 1ns/1ps
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             out_valid,
  output logic             busy
);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] counter;
  logic [WIDTH:0]   rem_w, rem_next;
  logic [WIDTH-1:0] quo_w, quo_next, dsr;
  logic             accept, short_path, last_step;

  assign accept     = (state == IDLE) && in_valid;
  assign short_path = (divisor == '0) || (dividend == '0);
  assign last_step  = (state == CALC) && (counter == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_w    (rem_w),
    .quo_w    (quo_w),
    .dsr      (dsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = short_path ? DONE : CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the working registers are reset too, so the block starts from a known state after an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_w   <= '0;
      quo_w   <= '0;
      dsr     <= '0;
      counter <= '0;
    end else if (accept) begin
      rem_w   <= '0;
      quo_w   <= dividend;
      dsr     <= divisor;
      counter <= '0;
    end else if (state == CALC) begin
      rem_w   <= rem_next;
      quo_w   <= quo_next;
      counter <= counter + 1'b1;
    end
  end

  // Results load only on entry to DONE and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept && short_path) begin
      if (divisor == '0) begin
        quotient    <= {WIDTH{DIV0_QUOTIENT_ALL_ONES}};
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (last_step) begin
      quotient    <= quo_next;
      remainder   <= rem_next[WIDTH-1:0];
      div_by_zero <= 1'b0;
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed and corner-biased random checks of seq_divider: results, latency,
// ignored requests while busy, back-to-back starts and asynchronous abort.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] dividend, divisor;
  logic [WIDTH-1:0] quotient, remainder;
  logic             div_by_zero, out_valid, busy;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .out_valid   (out_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE. Latency counts rising edges from the accept
  // edge to the edge that first samples out_valid high. Optionally pulses a
  // junk 8/2 request during CALC cycle pulse_calc and during the DONE cycle.
  // Returns at the negedge of the first IDLE cycle with in_valid low.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int pulse_calc, input bit pulse_done,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic dz, output int lat, output bit busy_ok);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    q = '0; r = '0; dz = 1'b0; lat = 0; busy_ok = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      in_valid = (k == pulse_calc);
      if (k == pulse_calc) begin
        dividend = 32'd8;
        divisor  = 32'd2;
      end
      if (!busy) busy_ok = 1'b0;
      if (out_valid) begin
        lat = k;
        q   = quotient;
        r   = remainder;
        dz  = div_by_zero;
        break;
      end
    end
    in_valid = pulse_done;
    if (pulse_done) begin
      dividend = 32'd8;
      divisor  = 32'd2;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("ov_one_cycle", 32'(out_valid), 32'd0);
    check("idle_busy_low", 32'(busy), 32'd0);
  endtask

  logic [31:0] q, r, a, b;
  logic        dz;
  int          lat, ov_count;
  bit          busy_ok;
  logic [63:0] prod;

  initial begin
    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7, full iterative path
    run_op(32'd100, 32'd7, 0, 1'b0, q, r, dz, lat, busy_ok);
    check("d100_7_q", q, 32'd14);
    check("d100_7_r", r, 32'd2);
    check("d100_7_dbz", 32'(dz), 32'd0);
    check("d100_7_lat", lat, 32'(WIDTH + 1));
    check("d100_7_busy", 32'(busy_ok), 32'd1);

    // divide by zero, short path
    run_op(32'd5, 32'd0, 0, 1'b0, q, r, dz, lat, busy_ok);
    check("d5_0_q", q, 32'hFFFF_FFFF);
    check("d5_0_r", r, 32'd5);
    check("d5_0_dbz", 32'(dz), 32'd1);
    check("d5_0_lat", lat, 32'd1);

    // zero dividend, short path
    run_op(32'd0, 32'd9, 0, 1'b0, q, r, dz, lat, busy_ok);
    check("d0_9_q", q, 32'd0);
    check("d0_9_r", r, 32'd0);
    check("d0_9_dbz", 32'(dz), 32'd0);
    check("d0_9_lat", lat, 32'd1);

    run_op(32'hFFFF_FFFF, 32'd1, 0, 1'b0, q, r, dz, lat, busy_ok);
    check("dmax_1_q", q, 32'hFFFF_FFFF);
    check("dmax_1_r", r, 32'd0);
    check("dmax_1_lat", lat, 32'(WIDTH + 1));

    run_op(32'd3, 32'h8000_0000, 0, 1'b0, q, r, dz, lat, busy_ok);
    check("d3_msb_q", q, 32'd0);
    check("d3_msb_r", r, 32'd3);

    // requests during CALC and DONE are ignored, then an immediate second op
    run_op(32'd1000, 32'd3, 10, 1'b1, q, r, dz, lat, busy_ok);
    check("d1000_3_q", q, 32'd333);
    check("d1000_3_r", r, 32'd1);
    check("d1000_3_lat", lat, 32'(WIDTH + 1));
    check("d1000_3_busy", 32'(busy_ok), 32'd1);
    run_op(32'd8, 32'd2, 0, 1'b0, q, r, dz, lat, busy_ok);
    check("b2b_8_2_q", q, 32'd4);
    check("b2b_8_2_r", r, 32'd0);
    check("b2b_8_2_lat", lat, 32'(WIDTH + 1));

    // asynchronous reset in the middle of 1000 / 3
    in_valid = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ov_count = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_count++;
    end
    check("abort_no_ov", ov_count, 32'd0);
    run_op(32'd50, 32'd5, 0, 1'b0, q, r, dz, lat, busy_ok);
    check("d50_5_q", q, 32'd10);
    check("d50_5_r", r, 32'd0);

    // corner-biased random operands against the division invariant
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'd0;
        1:       a = 32'd1;
        2:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom_range(2, 1000);
        default: b = $urandom;
      endcase
      run_op(a, b, 0, 1'b0, q, r, dz, lat, busy_ok);
      check("rand_lat", lat, (a == 0 || b == 0) ? 32'd1 : 32'(WIDTH + 1));
      if (b == 0) begin
        check("rand_div0_q", q, 32'hFFFF_FFFF);
        check("rand_div0_r", r, a);
        check("rand_div0_dbz", 32'(dz), 32'd1);
      end else begin
        prod = 64'(q) * 64'(b) + 64'(r);
        check("rand_inv_lo", prod[31:0], a);
        check("rand_inv_hi", prod[63:32], 32'd0);
        check("rand_rem_lt", 32'(r < b), 32'd1);
        check("rand_dbz", 32'(dz), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
